// File: rtl/intc_pkg.sv
// Shared types and register map for the interrupt controller.
// Used by intr_ctrl and intc_prio_enc.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } intc_state_e;

  localparam logic [3:0] OFF_PEND = 4'h0;
  localparam logic [3:0] OFF_MASK = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;
  localparam logic [3:0] OFF_EOI  = 4'hC;

  localparam int CTRL_GIE    = 0;
  localparam int CTRL_ID_LSB = 8;
  localparam int CTRL_ID_MSB = 11;
  localparam int CTRL_ST_LSB = 16;
  localparam int CTRL_ST_MSB = 17;

  localparam int DEBUG_W = 13;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational winner search over request lines.
// Search starts at base and wraps modulo NSRC.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IDW-1:0]  base,
  output logic            any,
  output logic [IDW-1:0]  id
);

  logic [IDW-1:0] w_j;

  // Scan from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    any = |req;
    id  = '0;
    w_j = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      w_j = IDW'((int'(base) + k) % NSRC);
      if (req[w_j]) id = w_j;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: PEND/MASK/CTRL/EOI window, IRQ/IDN out.
// Define INTC_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int              BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hF000_0800,
  parameter int              NSRC = 8,
  parameter int              IDW  = $clog2(NSRC)
) (
  input  logic                 CLK,
  input  logic                 LOCK,
  input  logic [BITS-1:0]      ABUS,
  inout  wire  [BITS-1:0]      DBUS,
  input  logic                 WE,
  input  logic                 FLUSH,
  input  logic [NSRC-1:0]      IRQ_IN,
  input  logic                 INTA,
  output logic                 IRQ,
  output logic [IDW-1:0]       IDN,
  output logic [DEBUG_W-1:0]   DEBUG
);

  intc_state_e     r_state;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic            r_gie;
  logic [IDW-1:0]  r_cur_id;
  logic            r_irq;

  logic [3:0]      w_off;
  logic            w_sel;
  logic            w_wr;
  logic            w_eoi;
  logic [NSRC-1:0] w_elig;
  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_base;
  logic [BITS-1:0] w_ctrl;
  logic [BITS-1:0] w_rd_data;
  logic            w_rd_hit;
  logic [3:0]      w_id4;
  logic [5:0]      w_pend6;
  logic            w_unused_dbus;

  assign w_off = ABUS[3:0];
  assign w_sel = (ABUS[BITS-1:4] == BASE[BITS-1:4]) && !FLUSH;
  assign w_wr  = w_sel && WE;
  assign w_eoi = w_wr && (w_off == OFF_EOI);

  assign w_unused_dbus = ^DBUS[BITS-1:NSRC];

  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      r_pend <= '0;
    end else begin
      r_pend <= IRQ_IN;
    end
  end

  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      r_mask <= '0;
      r_gie  <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_MASK)) r_mask <= DBUS[NSRC-1:0];
      if (w_wr && (w_off == OFF_CTRL)) r_gie  <= DBUS[CTRL_GIE];
    end
  end

  assign w_elig = r_pend & r_mask & {NSRC{r_gie}};

  intc_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio (
    .req  (w_elig),
    .base (w_base),
    .any  (w_any),
    .id   (w_win)
  );

`ifdef INTC_ROUND_ROBIN_EN
  logic [IDW-1:0] r_rr_base;

  // The acknowledged source drops to lowest priority for the next search.
  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      r_rr_base <= '0;
    end else if ((r_state == REQ) && INTA) begin
      r_rr_base <= (r_cur_id == IDW'(NSRC - 1)) ? '0 : r_cur_id + 1'b1;
    end
  end

  assign w_base = r_rr_base;
`else
  assign w_base = '0;
`endif

  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      r_state  <= IDLE;
      r_cur_id <= '0;
      r_irq    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cur_id <= w_win;
            r_state  <= REQ;
            r_irq    <= 1'b1;
          end
        end
        REQ: begin
          if (INTA) begin
            r_state <= SERV;
            r_irq   <= 1'b0;
          end else if (!w_any) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
          end else begin
            r_cur_id <= w_win;
          end
        end
        SERV: begin
          if (w_eoi) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign IRQ = r_irq;
  assign IDN = r_cur_id;

  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_GIE] = r_gie;
    w_ctrl[CTRL_ID_MSB:CTRL_ID_LSB] = 4'(r_cur_id);
    w_ctrl[CTRL_ST_MSB:CTRL_ST_LSB] = r_state;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_hit  = 1'b1;
    unique case (1'b1)
      (w_off == OFF_PEND): w_rd_data = BITS'(r_pend);
      (w_off == OFF_MASK): w_rd_data = BITS'(r_mask);
      (w_off == OFF_CTRL): w_rd_data = w_ctrl;
      (w_off == OFF_EOI):  w_rd_data = '0;
      default:             w_rd_hit  = 1'b0;
    endcase
  end

  assign DBUS = (w_sel && !WE && w_rd_hit) ? w_rd_data : {BITS{1'bz}};

  assign w_id4 = 4'(r_cur_id);

  if (NSRC >= 6) begin : g_dbg_wide
    assign w_pend6 = r_pend[5:0];
  end else begin : g_dbg_narrow
    assign w_pend6 = 6'(r_pend);
  end

  assign DEBUG = {r_state, r_gie, w_id4, w_pend6};

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios then random traffic vs a cycle model.
// Build with +define+INTC_ROUND_ROBIN_EN to exercise rotating priority.
module tb_intr_ctrl;

  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'hF000_0800;
  localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;
  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_SERV = 2;

`ifdef INTC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        lock;
  logic [31:0] abus;
  logic        we;
  logic        flush;
  logic [7:0]  irq_in;
  logic        inta;
  logic        irq;
  logic [2:0]  idn;
  logic [12:0] dbg;
  logic        drv;
  logic [31:0] wdata;
  wire  [31:0] dbus;

  assign dbus = drv ? wdata : 32'bz;
  pullup (dbus);

  intr_ctrl u_dut (
    .CLK    (clk),
    .LOCK   (lock),
    .ABUS   (abus),
    .DBUS   (dbus),
    .WE     (we),
    .FLUSH  (flush),
    .IRQ_IN (irq_in),
    .INTA   (inta),
    .IRQ    (irq),
    .IDN    (idn),
    .DEBUG  (dbg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int       m_st;
  int       m_id;
  int       m_rr;
  bit       m_gie;
  bit [7:0] m_pend;
  bit [7:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_id = 0; m_rr = 0;
    m_gie = 0; m_pend = 0; m_mask = 0;
  endtask

  // Closest eligible source at or after start, cyclically; -1 if none.
  function automatic int pick(bit [7:0] e, int start);
    int best, bestd, d;
    best = -1;
    bestd = NSRC;
    for (int i = 0; i < NSRC; i++) begin
      d = (i - start + NSRC) % NSRC;
      if (e[i] && d < bestd) begin
        bestd = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] rd_exp(logic [31:0] a, bit fl);
    logic [31:0] d;
    d = a - BASE;
    if (fl || d >= 16 || d[1:0] != 2'b00) return ZBUS;
    case (d)
      0: return {24'h0, m_pend};
      4: return {24'h0, m_mask};
      8: return (m_st << 16) + (m_id << 8) + m_gie;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit [7:0]    elig;
    int          w;
    logic [31:0] d;
    bit          wsel;
    if (!lock) begin
      model_reset();
      return;
    end
    elig = m_gie ? (m_pend & m_mask) : 8'h0;
    w = pick(elig, RR ? m_rr : 0);
    d = abus - BASE;
    wsel = !flush && we && (d < 16);
    case (m_st)
      S_IDLE: if (w >= 0) begin m_id = w; m_st = S_REQ; end
      S_REQ: begin
        if (inta) begin
          m_st = S_SERV;
          if (RR) m_rr = (m_id + 1) % NSRC;
        end else if (w < 0) m_st = S_IDLE;
        else m_id = w;
      end
      default: if (wsel && d == 12) m_st = S_IDLE;
    endcase
    if (wsel && d == 4) m_mask = wdata[7:0];
    if (wsel && d == 8) m_gie = wdata[0];
    m_pend = irq_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq", irq, (m_st == S_REQ) ? 1 : 0);
    chk("idn", idn, m_id);
    chk("debug", dbg, m_st * 2048 + m_gie * 1024 + m_id * 64 + (m_pend & 8'h3F));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    abus = a; we = 1'b1; drv = 1'b1; wdata = d;
    step();
    we = 1'b0; drv = 1'b0; abus = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    abus = a; we = 1'b0; drv = 1'b0;
    #1;
    chk(tag, dbus, exp);
    abus = 32'h0;
  endtask

  task automatic wait_irq(input int max);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk("wait_irq", irq, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[3];
    logic [31:0] offs[6];
    int op;
    offs[0] = 0; offs[1] = 4; offs[2] = 8;
    offs[3] = 12; offs[4] = 16; offs[5] = 5;

    lock = 1'b1; abus = 0; we = 0; flush = 0;
    irq_in = 0; inta = 0; drv = 0; wdata = 0;
    model_reset();
    #1 lock = 1'b0;
    step();
    step();
    chk("rst irq", irq, 0);
    chk("rst idn", idn, 0);
    lock = 1'b1;

    // Fixed ordering, acknowledge and EOI.
    wr(BASE + 4, 32'hFF);
    wr(BASE + 8, 32'h1);
    irq_in = 8'h24;
    step();
    step();
    chk("t2 irq", irq, 1);
    chk("t2 idn", idn, 2);
    inta = 1'b1;
    step();
    inta = 1'b0;
    chk("t2 irq ack", irq, 0);
    rd("t2 ctrl", BASE + 8, rd_exp(BASE + 8, 0));
    chk("t2 state", {30'h0, dbg[12:11]}, S_SERV);
    irq_in = 8'h20;
    step();
    wr(BASE + 12, 32'h0);
    step();
    chk("t2 next idn", idn, 5);
    chk("t2 next irq", irq, 1);

    // Re-arbitration while pending, then request withdrawal.
    irq_in = 8'h22;
    step();
    step();
    chk("t3 idn", idn, 1);
    irq_in = 8'h00;
    step();
    step();
    chk("t3 irq", irq, 0);
    chk("t3 idle", {30'h0, dbg[12:11]}, S_IDLE);

    // EOI racing a new request; INTA in IDLE is ignored.
    irq_in = 8'h01;
    wait_irq(5);
    inta = 1'b1;
    step();
    inta = 1'b0;
    irq_in = 8'h00;
    step();
    irq_in = 8'h08;
    wr(BASE + 12, 32'h0);
    chk("t4 idle irq", irq, 0);
    chk("t4 idle st", {30'h0, dbg[12:11]}, S_IDLE);
    inta = 1'b1;
    step();
    inta = 1'b0;
    chk("t4 irq", irq, 1);
    chk("t4 idn", idn, 3);
    chk("t4 req st", {30'h0, dbg[12:11]}, S_REQ);
    inta = 1'b1;
    step();
    inta = 1'b0;
    irq_in = 8'h00;
    wr(BASE + 12, 32'h0);
    step();

    // Rotation across acknowledge rounds.
    if (RR) begin
      rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 0;
    end else begin
      rr_exp[0] = 0; rr_exp[1] = 0; rr_exp[2] = 0;
    end
    irq_in = 8'h03;
    for (int r = 0; r < 3; r++) begin
      wait_irq(6);
      chk($sformatf("t5 round%0d idn", r), idn, rr_exp[r]);
      inta = 1'b1;
      step();
      inta = 1'b0;
      wr(BASE + 12, 32'h0);
    end
    irq_in = 8'h00;
    step();
    step();

    // Flushed write, unmapped and write-only reads.
    flush = 1'b1;
    wr(BASE + 4, 32'h0F);
    rd("t6 flushed rd", BASE + 4, ZBUS);
    flush = 1'b0;
    rd("t6 mask", BASE + 4, 32'hFF);
    rd("t6 unmapped", BASE + 16, ZBUS);
    rd("t6 eoi rd", BASE + 12, 32'h0);
    step();

    // Asynchronous reset in the middle of a request.
    irq_in = 8'h10;
    wait_irq(5);
    lock = 1'b0;
    model_reset();
    #1;
    chk("t1 irq", irq, 0);
    chk("t1 idn", idn, 0);
    rd("t1 mask", BASE + 4, 32'h0);
    rd("t1 ctrl", BASE + 8, 32'h0);
    step();
    lock = 1'b1;
    step();

    wr(BASE + 4, 32'hFF);
    wr(BASE + 8, 32'h1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom & $urandom);
      inta = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      op = $urandom_range(0, 9);
      if (op < 2) begin
        wr(BASE + 4, $urandom);
      end else if (op == 2) begin
        wr(BASE + 8, {$urandom_range(0, 255), 23'h0, ($urandom_range(0, 4) != 0)});
      end else if (op < 5) begin
        wr(BASE + 12, $urandom);
      end else if (op < 7) begin
        abus = BASE + offs[$urandom_range(0, 5)];
        rd("rnd read", abus, rd_exp(abus, flush));
        step();
      end else begin
        step();
      end
    end
    inta = 1'b0;
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
